// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder-buffer commit interface.
package rob_commit_pkg;
  typedef enum logic {
    reg_commit_no_wb = 1'b0,
    reg_commit_wb    = 1'b1
  } commit_type_t;
endpackage

// File: rtl/rob_commit_unit_if.sv
// Issue/complete/flush inputs and per-slot retirement outputs of the reorder buffer.
interface rob_commit_unit_if #(
  parameter int ROB_SIZE_WIDTH         = 4,
  parameter int MAX_COMMITS            = 2,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6,
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int CMPL_PORTS             = 2
);
  import rob_commit_pkg::*;

  logic                                         alloc_valid;
  logic [ROB_SIZE_WIDTH-1:0]                    alloc_tag;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0]            alloc_phy_dst;
  logic [ARCH_REG_NUM_WIDTH-1:0]                alloc_arch_dst;
  logic                                         alloc_reg_wb;
  logic [CMPL_PORTS-1:0]                        cmpl_valid;
  logic [CMPL_PORTS-1:0][ROB_SIZE_WIDTH-1:0]    cmpl_tag;
  logic                                         flush;

  logic [MAX_COMMITS-1:0]                              commit_valid;
  commit_type_t [MAX_COMMITS-1:0]                      commit_type;
  logic [MAX_COMMITS-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]  commited_wr_register;
  logic [MAX_COMMITS-1:0][ARCH_REG_NUM_WIDTH-1:0]      commit_arch_reg;
  logic [MAX_COMMITS-1:0][ROB_SIZE_WIDTH-1:0]          commit_tag;
  logic [ROB_SIZE_WIDTH:0]                             occupancy;
  logic                                                proto_err;

  modport master (
    output alloc_valid, alloc_tag, alloc_phy_dst, alloc_arch_dst, alloc_reg_wb,
           cmpl_valid, cmpl_tag, flush,
    input  commit_valid, commit_type, commited_wr_register, commit_arch_reg,
           commit_tag, occupancy, proto_err
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_phy_dst, alloc_arch_dst, alloc_reg_wb,
           cmpl_valid, cmpl_tag, flush,
    output commit_valid, commit_type, commited_wr_register, commit_arch_reg,
           commit_tag, occupancy, proto_err
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: retires up to MAX_COMMITS oldest done entries per cycle, outputs
// registered (completion at edge N commits at N+1 earliest); no backpressure, misuse sets proto_err.
module rob_commit_unit
  import rob_commit_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH         = 4,
  parameter int MAX_COMMITS            = 2,
  parameter int PHYSICAL_REG_NUM_WIDTH = 6,
  parameter int ARCH_REG_NUM_WIDTH     = 5,
  parameter int CMPL_PORTS             = 2
) (
  input  logic             clk,
  input  logic             reset,
  rob_commit_unit_if.slave rob
);
  localparam int ROB_DEPTH = 1 << ROB_SIZE_WIDTH;
  localparam int OW        = ROB_SIZE_WIDTH + 1;

  typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

  logic [ROB_DEPTH-1:0]              ent_valid;
  logic [ROB_DEPTH-1:0]              ent_done;
  logic [ROB_DEPTH-1:0]              ent_reg_wb;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] ent_phy  [ROB_DEPTH];
  logic [ARCH_REG_NUM_WIDTH-1:0]     ent_arch [ROB_DEPTH];

  tag_t          head;
  tag_t          tail;
  logic [OW-1:0] occ;

  logic [MAX_COMMITS-1:0] sel;
  tag_t                   sel_idx [MAX_COMMITS];
  logic [OW-1:0]          sel_cnt;
  logic                   run;

  logic alloc_ok;
  logic alloc_err;
  logic cmpl_err;
  tag_t next_tail;

  // Selection stops at the first entry that is not both valid and done, keeping slots contiguous.
  always_comb begin
    sel     = '0;
    sel_cnt = '0;
    run     = 1'b1;
    for (int i = 0; i < MAX_COMMITS; i++) begin
      sel_idx[i] = head + tag_t'(i);
      run        = run & ent_valid[sel_idx[i]] & ent_done[sel_idx[i]];
      sel[i]     = run;
      sel_cnt    = sel_cnt + OW'(run);
    end
  end

  always_comb begin
    alloc_ok  = rob.alloc_valid & ~ent_valid[rob.alloc_tag];
    alloc_err = rob.alloc_valid &  ent_valid[rob.alloc_tag];
    cmpl_err  = 1'b0;
    for (int p = 0; p < CMPL_PORTS; p++) begin
      if (rob.cmpl_valid[p] && !ent_valid[rob.cmpl_tag[p]]) cmpl_err = 1'b1;
    end
    next_tail = alloc_ok ? (rob.alloc_tag + tag_t'(1)) : tail;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid                <= '0;
      ent_done                 <= '0;
      head                     <= '0;
      tail                     <= '0;
      occ                      <= '0;
      rob.proto_err            <= 1'b0;
      rob.commit_valid         <= '0;
      rob.commit_tag           <= '0;
      rob.commited_wr_register <= '0;
      rob.commit_arch_reg      <= '0;
      for (int i = 0; i < MAX_COMMITS; i++) rob.commit_type[i] <= reg_commit_no_wb;
    end else if (rob.flush) begin
      ent_valid                <= '0;
      ent_done                 <= '0;
      head                     <= next_tail;
      tail                     <= next_tail;
      occ                      <= '0;
      rob.commit_valid         <= '0;
      rob.commit_tag           <= '0;
      rob.commited_wr_register <= '0;
      rob.commit_arch_reg      <= '0;
      for (int i = 0; i < MAX_COMMITS; i++) rob.commit_type[i] <= reg_commit_no_wb;
    end else begin
      rob.commit_valid <= sel;
      for (int i = 0; i < MAX_COMMITS; i++) begin
        rob.commit_tag[i]           <= sel[i] ? sel_idx[i] : '0;
        rob.commited_wr_register[i] <= sel[i] ? ent_phy[sel_idx[i]] : '0;
        rob.commit_arch_reg[i]      <= sel[i] ? ent_arch[sel_idx[i]] : '0;
        rob.commit_type[i]          <= (sel[i] && ent_reg_wb[sel_idx[i]]) ? reg_commit_wb
                                                                          : reg_commit_no_wb;
      end
      // Order matters: completions, then retire clears, then the new allocation.
      for (int p = 0; p < CMPL_PORTS; p++) begin
        if (rob.cmpl_valid[p] && ent_valid[rob.cmpl_tag[p]]) ent_done[rob.cmpl_tag[p]] <= 1'b1;
      end
      for (int i = 0; i < MAX_COMMITS; i++) begin
        if (sel[i]) begin
          ent_valid[sel_idx[i]] <= 1'b0;
          ent_done[sel_idx[i]]  <= 1'b0;
        end
      end
      if (alloc_ok) begin
        ent_valid[rob.alloc_tag] <= 1'b1;
        ent_done[rob.alloc_tag]  <= 1'b0;
      end
      head          <= head + tag_t'(sel_cnt);
      tail          <= next_tail;
      occ           <= occ + OW'(alloc_ok) - sel_cnt;
      rob.proto_err <= rob.proto_err | alloc_err | cmpl_err;
    end
  end

  // Payload is only read through valid-gated selection, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok && !rob.flush) begin
      ent_phy[rob.alloc_tag]    <= rob.alloc_phy_dst;
      ent_arch[rob.alloc_tag]   <= rob.alloc_arch_dst;
      ent_reg_wb[rob.alloc_tag] <= rob.alloc_reg_wb;
    end
  end

  assign rob.occupancy = occ;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with an in-order scoreboard of expected retirements.
module tb_rob_commit_unit;
  import rob_commit_pkg::*;

  typedef struct packed {
    logic [3:0] tag;
    logic [5:0] phy;
    logic [4:0] arch;
    logic       wb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rob_commit_unit_if #(.ROB_SIZE_WIDTH(4), .MAX_COMMITS(2), .PHYSICAL_REG_NUM_WIDTH(6),
                       .ARCH_REG_NUM_WIDTH(5), .CMPL_PORTS(2)) rif ();

  rob_commit_unit #(.ROB_SIZE_WIDTH(4), .MAX_COMMITS(2), .PHYSICAL_REG_NUM_WIDTH(6),
                    .ARCH_REG_NUM_WIDTH(5), .CMPL_PORTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retirements must come out in allocation order with the recorded payload.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        if (rif.commit_valid[i] === 1'b1) begin
          chk("unexpected_commit", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_tag",  32'(rif.commit_tag[i]), 32'(e.tag));
            chk("sb_phy",  32'(rif.commited_wr_register[i]), 32'(e.phy));
            chk("sb_arch", 32'(rif.commit_arch_reg[i]), 32'(e.arch));
            chk("sb_type", 32'(rif.commit_type[i]),
                32'(e.wb ? reg_commit_wb : reg_commit_no_wb));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int tag, input int phy, input int arch, input bit wb,
                          input bit push);
    exp_t e;
    rif.alloc_valid    = 1'b1;
    rif.alloc_tag      = 4'(tag);
    rif.alloc_phy_dst  = 6'(phy);
    rif.alloc_arch_dst = 5'(arch);
    rif.alloc_reg_wb   = wb;
    if (push) begin
      e = '{tag: 4'(tag), phy: 6'(phy), arch: 5'(arch), wb: wb};
      sb.push_back(e);
    end
    step();
    rif.alloc_valid = 1'b0;
  endtask

  task automatic do_cmpl(input int t0, input bit v0, input int t1, input bit v1);
    rif.cmpl_valid  = {v1, v0};
    rif.cmpl_tag[0] = 4'(t0);
    rif.cmpl_tag[1] = 4'(t1);
    step();
    rif.cmpl_valid = 2'b00;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rif.occupancy != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rif.alloc_valid = 0; rif.alloc_tag = 0; rif.alloc_phy_dst = 0; rif.alloc_arch_dst = 0;
    rif.alloc_reg_wb = 0; rif.cmpl_valid = 0; rif.cmpl_tag = '0; rif.flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
    chk("rst_occupancy", 32'(rif.occupancy), 32'd0);
    chk("rst_proto_err", 32'(rif.proto_err), 32'd0);
    chk("rst_commit_type", 32'(rif.commit_type[0]), 32'(reg_commit_no_wb));

    // Out-of-order completion, in-order retirement.
    do_alloc(0, 10, 1, 1, 1);
    do_alloc(1, 11, 2, 0, 1);
    do_alloc(2, 12, 3, 1, 1);
    do_cmpl(2, 1, 0, 0);
    chk("t1_wait_tag2", 32'(rif.commit_valid), 32'd0);
    do_cmpl(1, 1, 0, 0);
    chk("t1_wait_tag1", 32'(rif.commit_valid), 32'd0);
    do_cmpl(0, 1, 0, 0);
    chk("t1_not_same_cycle", 32'(rif.commit_valid), 32'd0);
    step();
    chk("t1_first_pair", 32'(rif.commit_valid), 32'b11);
    chk("t1_slot0_tag", 32'(rif.commit_tag[0]), 32'd0);
    chk("t1_slot1_tag", 32'(rif.commit_tag[1]), 32'd1);
    step();
    chk("t1_second", 32'(rif.commit_valid), 32'b01);
    chk("t1_second_tag", 32'(rif.commit_tag[0]), 32'd2);
    step();
    chk("t1_idle", 32'(rif.commit_valid), 32'd0);
    chk("t1_occ", 32'(rif.occupancy), 32'd0);

    // Fresh start, then payload and commit type.
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    do_alloc(0, 7, 3, 1, 1);
    do_alloc(1, 9, 4, 0, 1);
    do_cmpl(0, 1, 1, 1);
    step();
    chk("t2_valid", 32'(rif.commit_valid), 32'b11);
    chk("t2_type0", 32'(rif.commit_type[0]), 32'(reg_commit_wb));
    chk("t2_phy0", 32'(rif.commited_wr_register[0]), 32'd7);
    chk("t2_arch0", 32'(rif.commit_arch_reg[0]), 32'd3);
    chk("t2_type1", 32'(rif.commit_type[1]), 32'(reg_commit_no_wb));
    step();

    // Walk head up to 15, then retire across the wrap.
    for (int t = 2; t <= 14; t++) do_alloc(t, t + 20, t, t[0], 1);
    for (int t = 2; t <= 14; t += 2) do_cmpl(t, 1, t + 1, (t + 1) <= 14);
    drain(40);
    chk("t3_proto_err", 32'(rif.proto_err), 32'd0);
    do_alloc(15, 40, 15, 1, 1);
    do_alloc(0, 41, 16, 0, 1);
    do_cmpl(15, 1, 0, 1);
    step();
    chk("t3_wrap_valid", 32'(rif.commit_valid), 32'b11);
    chk("t3_wrap_tag0", 32'(rif.commit_tag[0]), 32'd15);
    chk("t3_wrap_tag1", 32'(rif.commit_tag[1]), 32'd0);
    step();

    // Full buffer, then alloc alongside a two-wide commit.
    for (int k = 0; k < 16; k++) do_alloc((1 + k) % 16, k + 1, k, k[0], 1);
    chk("t4_full", 32'(rif.occupancy), 32'd16);
    chk("t4_no_err", 32'(rif.proto_err), 32'd0);
    do_cmpl(1, 1, 2, 1);
    step();
    chk("t4_commit_from_head1", 32'(rif.commit_tag[0]), 32'd1);
    chk("t4_occ14", 32'(rif.occupancy), 32'd14);
    do_alloc(1, 50, 20, 1, 1);
    chk("t4_occ15", 32'(rif.occupancy), 32'd15);
    do_cmpl(3, 1, 4, 1);
    do_alloc(2, 51, 21, 0, 1);
    chk("t4_same_edge_valid", 32'(rif.commit_valid), 32'b11);
    chk("t4_same_edge_occ", 32'(rif.occupancy), 32'd14);

    // Flush beats a same-cycle alloc (tag 3) and completion (tag 5).
    rif.flush = 1'b1;
    rif.cmpl_valid = 2'b01;
    rif.cmpl_tag[0] = 4'd5;
    do_alloc(3, 60, 22, 1, 0);
    rif.flush = 1'b0;
    rif.cmpl_valid = 2'b00;
    sb.delete();
    chk("t5_flush_valid", 32'(rif.commit_valid), 32'd0);
    chk("t5_flush_occ", 32'(rif.occupancy), 32'd0);
    step();
    chk("t5_after_valid", 32'(rif.commit_valid), 32'd0);
    do_alloc(4, 61, 23, 0, 1);
    do_cmpl(4, 1, 0, 0);
    step();
    chk("t5_head_eq_tail", 32'(rif.commit_valid), 32'b01);
    chk("t5_tag4", 32'(rif.commit_tag[0]), 32'd4);
    chk("t5_no_err", 32'(rif.proto_err), 32'd0);

    // Protocol violations leave state alone and stick.
    do_cmpl(9, 1, 0, 0);
    chk("t6_cmpl_invalid_err", 32'(rif.proto_err), 32'd1);
    chk("t6_occ0", 32'(rif.occupancy), 32'd0);
    do_alloc(5, 11, 6, 1, 1);
    chk("t6_flushed_done_gone", 32'(rif.commit_valid), 32'd0);
    do_alloc(5, 33, 7, 0, 0);
    chk("t6_dup_alloc_occ", 32'(rif.occupancy), 32'd1);
    do_cmpl(5, 1, 5, 1);
    step();
    chk("t6_commit_valid", 32'(rif.commit_valid), 32'b01);
    chk("t6_orig_phy", 32'(rif.commited_wr_register[0]), 32'd11);
    step();
    chk("t6_sticky", 32'(rif.proto_err), 32'd1);

    // Reset just before a retirement would be emitted.
    do_alloc(6, 12, 8, 1, 1);
    do_cmpl(6, 1, 0, 0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rst2_async_valid", 32'(rif.commit_valid), 32'd0);
    step();
    chk("rst2_valid", 32'(rif.commit_valid), 32'd0);
    chk("rst2_proto_err", 32'(rif.proto_err), 32'd0);
    chk("rst2_occ", 32'(rif.occupancy), 32'd0);
    reset = 1'b0;
    step();
    chk("end_valid", 32'(rif.commit_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
